// File: rtl/csa_mult_arbiter.sv
// csa_mult_arbiter: round-robin arbiter and sequencer that shares one 4x4
// carry-save array multiplier between two requesters. Operands are accepted
// over a valid/ready handshake. The product is returned with the requester
// ID over a valid/ready response channel.
// Optional feature: define CSA_MULT_ARB_STATS_EN to add the saturating
// per-requester grant counters grant_cnt0 / grant_cnt1.

// 4x4 -> 8-bit unsigned carry-save array multiplier (purely combinational).
// Each row adds one partial-product row to the sum/carry vectors of the
// previous row without propagating carries. The low sum bit of each row is
// a finished product bit. A short ripple add merges the last row.
module csa_multiplier (
  input  logic [3:0] m,
  input  logic [3:0] q,
  output logic [7:0] p
);

  logic [3:0][3:0] w_pp;
  logic [3:0][3:0] w_s;
  logic [3:0][3:0] w_c;

  // Partial products, carry-save rows, and final carry-propagate merge.
  always_comb begin : csa_array
    logic [3:0] sh;
    logic       a;
    logic       b;
    logic       ci;
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    w_pp = '0;
    w_s  = '0;
    w_c  = '0;
    p    = '0;
    sh   = '0;
    a    = 1'b0;
    b    = 1'b0;
    ci   = 1'b0;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_pp[i][j] = m[j] & q[i];
      end
    end

    // Row 0 is the first partial-product row with no carries.
    w_s[0] = w_pp[0];

    // Row i: at weight i+j the inputs are pp[i][j], the previous sum bit one
    // position up, and the previous carry bit at the same position.
    for (int i = 1; i < 4; i++) begin
      sh = w_s[i-1] >> 1;
      for (int j = 0; j < 4; j++) begin
        a  = w_pp[i][j];
        b  = sh[j];
        ci = w_c[i-1][j];
        w_s[i][j] = a ^ b ^ ci;
        w_c[i][j] = (a & b) | (a & ci) | (b & ci);
      end
    end

    // Low nibble: the low sum bit retired by each row.
    p[3:0] = {w_s[3][0], w_s[2][0], w_s[1][0], w_s[0][0]};
    // High nibble: merge the remaining sum bits with the last carry row.
    p[7:4] = {1'b0, w_s[3][3:1]} + w_c[3];
  end

endmodule

module csa_mult_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_m,
  input  logic [3:0] req0_q,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_m,
  input  logic [3:0] req1_q,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_p,
  output logic       rsp_id,
  input  logic       rsp_ready,
`ifdef CSA_MULT_ARB_STATS_EN
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_m;
  logic [3:0] r_q;
  logic       r_id;
  logic       r_last_grant;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_p;
  logic       r_rsp_id;
  logic       r_busy;

  logic       w_grant_any;
  logic       w_grant_id;
  logic [7:0] w_p;

  // Arbitration: with both requesters valid, the one that did not win last
  // time is chosen; a lone requester is granted regardless of the pointer.
  always_comb begin
    w_grant_any = (r_state == S_IDLE) && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else begin
      w_grant_id = req1_valid;
    end
  end

  // Ready is the grant itself, so at most one requester sees it per cycle.
  assign req0_ready = w_grant_any && !w_grant_id;
  assign req1_ready = w_grant_any &&  w_grant_id;

  csa_multiplier u_mult (
    .m (r_m),
    .q (r_q),
    .p (w_p)
  );

  // Sequencer FSM with registered response and busy outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_m          <= '0;
      r_q          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_p      <= '0;
      r_rsp_id     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_m          <= w_grant_id ? req1_m : req0_m;
            r_q          <= w_grant_id ? req1_q : req0_q;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_busy       <= 1'b1;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          r_rsp_p     <= w_p;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp_p;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;

`ifdef CSA_MULT_ARB_STATS_EN
  logic [7:0] r_grant_cnt0;
  logic [7:0] r_grant_cnt1;

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (r_grant_cnt0 != 8'hFF)) begin
        r_grant_cnt0 <= r_grant_cnt0 + 8'd1;
      end
      if (req1_ready && (r_grant_cnt1 != 8'hFF)) begin
        r_grant_cnt1 <= r_grant_cnt1 + 8'd1;
      end
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule
